// File: rtl/minmax_pkg.sv
// Shared types and sizing helpers for the min/max window tracker.
package minmax_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic int cw_of(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/comparator_Nbit.sv
// Unsigned N-bit magnitude comparator: g when a > b, l when a < b.
module comparator_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         g,
  output logic         l
);

  assign g = (a > b);
  assign l = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Windowed running max/min tracker over unsigned samples.
// Define MINMAX_INDEX_EN to add max_idx/min_idx position outputs.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int N      = 4,
  parameter int WINDOW = 4,
  parameter int CW     = cw_of(WINDOW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic [CW-1:0] sample_cnt,
  output logic [N-1:0]  res_max,
  output logic [N-1:0]  res_min,
`ifdef MINMAX_INDEX_EN
  output logic [CW-1:0] max_idx,
  output logic [CW-1:0] min_idx,
`endif
  output logic          window_done,
  output logic          out_valid
);

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  cur_max;
  logic [N-1:0]  cur_min;
  logic          g_max;
  logic          l_max;
  logic          g_min;
  logic          l_min;
  logic          take;
  logic          last;
  logic          upd_max;
  logic          upd_min;
  logic [N-1:0]  nx_max;
  logic [N-1:0]  nx_min;
  logic          unused_cmp;

  comparator_Nbit #(.N(N)) u_cmp_max (
    .a (in_data),
    .b (cur_max),
    .g (g_max),
    .l (l_max)
  );

  comparator_Nbit #(.N(N)) u_cmp_min (
    .a (in_data),
    .b (cur_min),
    .g (g_min),
    .l (l_min)
  );

  assign unused_cmp = &{1'b0, l_max, g_min};

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear)
      state_nx = EMPTY;
    else if (in_valid)
      state_nx = last ? EMPTY : TRACK;
  end

  always_comb begin
    take    = in_valid && !clear;
    last    = (sample_cnt == CW'(WINDOW - 1));
    upd_max = (state == EMPTY) || g_max;
    upd_min = (state == EMPTY) || l_min;
    nx_max  = upd_max ? in_data : cur_max;
    nx_min  = upd_min ? in_data : cur_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_max     <= '0;
      cur_min     <= '0;
      sample_cnt  <= '0;
      res_max     <= '0;
      res_min     <= '0;
      window_done <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (clear) begin
        sample_cnt <= '0;
      end else if (take) begin
        cur_max <= nx_max;
        cur_min <= nx_min;
        if (last) begin
          sample_cnt  <= '0;
          res_max     <= nx_max;
          res_min     <= nx_min;
          window_done <= 1'b1;
          out_valid   <= 1'b1;
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

`ifdef MINMAX_INDEX_EN
  logic [CW-1:0] cur_max_idx;
  logic [CW-1:0] cur_min_idx;
  logic [CW-1:0] nx_max_idx;
  logic [CW-1:0] nx_min_idx;

  // Strict compares leave ties on the earlier position.
  assign nx_max_idx = upd_max ? sample_cnt : cur_max_idx;
  assign nx_min_idx = upd_min ? sample_cnt : cur_min_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_max_idx <= '0;
      cur_min_idx <= '0;
      max_idx     <= '0;
      min_idx     <= '0;
    end else if (take) begin
      cur_max_idx <= nx_max_idx;
      cur_min_idx <= nx_min_idx;
      if (last) begin
        max_idx <= nx_max_idx;
        min_idx <= nx_min_idx;
      end
    end
  end
`endif

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Sequential stage that consumes comparator results. Accepts a stream of unsigned N-bit samples and tracks the running maximum and minimum over fixed windows of WINDOW samples.
- Internally feeds two comparator_Nbit instances: sample vs current max, and sample vs current min. Updates are driven by their g/l outputs.
- At each window end it publishes registered results and a one-cycle done pulse to downstream logic.

Parameters:
- N, 4: sample width in bits (unsigned).
- WINDOW, 4: samples per window, at least 1.
- CW, $clog2(WINDOW+1): width of sample_cnt and the index ports; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort of the current partial window.
- in_valid  in  1  sample qualifier; the sample is accepted on the rising edge while high.
- in_data  in  N  sample value.
- sample_cnt  out  CW  samples accepted in the current window.
- res_max  out  N  maximum of the last completed window.
- res_min  out  N  minimum of the last completed window.
- window_done  out  1  one-cycle pulse when the results update.
- out_valid  out  1  high once at least one window has completed since rst.

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-high (rst). Applying rst forces the following on the next edge:
  - state = EMPTY;
  - cur_max, cur_min, sample_cnt, res_max, res_min = 0;
  - window_done, out_valid = 0.
- rst has priority over everything, including mid-window.
- State machine: two states, EMPTY and TRACK.
- EMPTY:
  - in_valid=1 loads cur_max = cur_min = in_data and sets sample_cnt = 1.
  - Next state is TRACK. If WINDOW==1, the window completes immediately instead (see completion).
- TRACK:
  - in_valid=1: comparator A=in_data, B=cur_max; g=1 → cur_max <= in_data.
  - Comparator A=in_data, B=cur_min; l=1 → cur_min <= in_data.
  - Equal values cause no update.
  - sample_cnt increments.
- in_valid=0 in either state: all state is held.
- Completion (the accepted sample is the WINDOW-th), on the same edge:
  - res_max and res_min take the final values, including this sample's effect.
  - window_done=1 for exactly the next cycle; out_valid=1.
  - sample_cnt = 0; state = EMPTY.
- Latency: 1 cycle from the last sample edge to window_done and results.
- Back-to-back windows: a sample with in_valid in the cycle after completion is taken as the first sample of the next window. No bubble.
- Result hold: res_max, res_min and out_valid hold until the next completion or rst.
- clear:
  - Sets state = EMPTY and sample_cnt = 0; the partial max/min are discarded.
  - res_*, out_valid and any in-flight window_done are unaffected.
  - clear has priority over in_valid in the same cycle; that sample is dropped.
- Comparisons are unsigned N-bit; no arithmetic beyond the CW-bit counter, which never exceeds WINDOW.

Optional Feature:
- Macro: MINMAX_INDEX_EN.
- Defined:
  - Adds outputs max_idx (CW) and min_idx (CW): the 0-based position within the window of the first occurrence of res_max / res_min.
  - Tracked alongside cur_max and cur_min; ties keep the earlier index.
  - Registered and reset exactly like res_*.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package minmax_pkg:
  - state enum typedef state_t {EMPTY, TRACK};
  - localparam helper for CW.
- Sub-module: reuse the existing comparator_Nbit, two instances (max path, min path). No new sub-module.

Test Plan (N=4, WINDOW=4 unless stated):
- Reset: hold rst 2 cycles → all outputs 0, sample_cnt=0, out_valid=0.
- Stream 10,11,8,10 with continuous valid → window_done high for exactly 1 cycle after the 4th edge; res_max=11, res_min=8; with MINMAX_INDEX_EN, max_idx=1 and min_idx=2.
- Stream 5,5,5,5 with in_valid gaps between samples → sample_cnt holds during gaps; res_max=res_min=5; indices 0,0.
- Apply clear after samples 3,9; next window 0,1,15,3:
  - prior results are held during the aborted window;
  - final res_max=15, res_min=0;
  - clear coinciding with in_valid drops that sample.
- 8 consecutive valid samples 1..8 → two window_done pulses 4 cycles apart, results 4/1 then 8/5, no bubble.
- rst asserted after 2 samples of a window → next edge clears everything, including out_valid; a subsequent full window 7,2,9,0 gives res_max=9, res_min=0.
